conv_window_gen: RTL and testbench

- Sliding-window generator for the convolution datapath. It takes a row-major pixel stream and produces one full 3x3 window per valid output position.
- Internally built from two line-delay chains (depth IMG_W, clock-enabled per accepted pixel) plus a 3x3 window register array.
- Sits directly upstream of the MAC/PE array. Frames are bounded by a start pulse and a frame_done pulse.

---
 rtl/conv_window_gen.sv | 177 +++++++++++++++++
 tb/tb_conv_window_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: 3x3 sliding-window generator over a row-major pixel stream.
// Latency: accept -> win_valid is 1 cycle (2 cycles when WINDOW_OUT_REG_EN is defined).
// Backpressure: in_ready is high only while a frame is running; it is not
//   affected by the consumer, so win_valid/frame_done are one-cycle pulses.
//
// Optional build macro: WINDOW_OUT_REG_EN adds a register stage on win_data,
//   win_valid and frame_done. The FSM timing is the same either way.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle pulse that arms a frame (ignored unless idle)
//   in_valid/in_data/in_ready   pixel input handshake
//   win_valid/win_data          window output, element i = 3*row + col, i=8 newest
//   frame_done      one-cycle pulse after the last pixel of a frame
module conv_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int STRIDE     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic                    win_valid,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic w_accept;
  logic w_last_col;
  logic w_last_pix;
  logic w_row_ok;
  logic w_col_ok;
  logic w_emit;

  // Two line delays: r_lb1 tap is the pixel one row above, r_lb2 tap two rows above.
  logic [DATA_WIDTH-1:0] r_lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] r_lb2 [IMG_W];
  logic [DATA_WIDTH-1:0] r_win [9];

  logic                    r_win_vld;
  logic                    r_done;
  logic [9*DATA_WIDTH-1:0] w_win_flat;

  assign in_ready   = (r_state == S_RUN);
  assign w_accept   = in_valid && in_ready;
  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_pix = w_last_col && (r_row == RW'(IMG_H - 1));

  // Stride phase is measured from the first complete window at (2,2).
  assign w_row_ok = (int'(r_row) >= 2) && (((int'(r_row) - 2) % STRIDE) == 0);
  assign w_col_ok = (int'(r_col) >= 2) && (((int'(r_col) - 2) % STRIDE) == 0);
  assign w_emit   = w_row_ok && w_col_ok;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_accept && w_last_pix) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Position counters; they return to 0 after the last pixel so the next
  // frame starts clean without needing the start pulse to clear them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line delays and window array shift only on accepted pixels. Contents are
  // deliberately kept across frames: row gating hides anything stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < IMG_W; k++) begin
        r_lb1[k] <= '0;
        r_lb2[k] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_accept) begin
      r_lb1[0] <= in_data;
      r_lb2[0] <= r_lb1[IMG_W-1];
      for (int k = 1; k < IMG_W; k++) begin
        r_lb1[k] <= r_lb1[k-1];
        r_lb2[k] <= r_lb2[k-1];
      end
      for (int rr = 0; rr < 3; rr++) begin
        r_win[3*rr]     <= r_win[3*rr+1];
        r_win[3*rr + 1] <= r_win[3*rr+2];
      end
      r_win[2] <= r_lb2[IMG_W-1];
      r_win[5] <= r_lb1[IMG_W-1];
      r_win[8] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_vld <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_win_vld <= w_accept && w_emit;
      r_done    <= w_accept && w_last_pix;
    end
  end

  always_comb begin
    w_win_flat = '0;
    for (int i = 0; i < 9; i++) begin
      w_win_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_win[i];
    end
  end

`ifdef WINDOW_OUT_REG_EN
  // Output stage runs freely so it drains after the FSM has gone idle.
  logic                    r_out_vld;
  logic                    r_out_done;
  logic [9*DATA_WIDTH-1:0] r_out_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_vld  <= 1'b0;
      r_out_done <= 1'b0;
      r_out_dat  <= '0;
    end else begin
      r_out_vld  <= r_win_vld;
      r_out_done <= r_done;
      r_out_dat  <= w_win_flat;
    end
  end

  assign win_valid  = r_out_vld;
  assign frame_done = r_out_done;
  assign win_data   = r_out_dat;
`else
  assign win_valid  = r_win_vld;
  assign frame_done = r_done;
  assign win_data   = w_win_flat;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: two instances (stride 1 and stride 2) share one
// input stream; a frame-image reference model predicts every window and the
// exact cycle of each win_valid / frame_done pulse.
module tb_conv_window_gen;

  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int WD = 9 * DW;
  localparam int N1 = ((H - 3) / 1 + 1) * ((W - 3) / 1 + 1);
  localparam int N2 = ((H - 3) / 2 + 1) * ((W - 3) / 2 + 1);
`ifdef WINDOW_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready1, in_ready2;
  logic          win_valid1, win_valid2;
  logic [WD-1:0] win_data1, win_data2;
  logic          frame_done1, frame_done2;

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .STRIDE(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .win_valid(win_valid1), .win_data(win_data1),
    .frame_done(frame_done1)
  );

  conv_window_gen #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .STRIDE(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .win_valid(win_valid2), .win_data(win_data2),
    .frame_done(frame_done2)
  );

  typedef struct {
    int            cyc;
    logic [WD-1:0] dat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   qd[$];

  logic [DW-1:0] img [H][W];
  int  n_chk = 0;
  int  n_err = 0;
  int  cyc   = 0;
  bit  m_run = 0;
  bit  m_done = 0;
  bit  m_acc = 0;
  int  m_cnt = 0;
  int  n1, n2;
  logic [WD-1:0] first1, last1, second2;

  task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d obs=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit emits(input int r, input int c, input int s);
    return (r >= 2) && (c >= 2) && ((r - 2) % s == 0) && ((c - 2) % s == 0);
  endfunction

  function automatic logic [WD-1:0] model_window(input int r, input int c);
    logic [WD-1:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[(3*dr + dc)*DW +: DW] = img[r-2+dr][c-2+dc];
    return w;
  endfunction

  function automatic logic [WD-1:0] pack9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    logic [WD-1:0] w;
    w = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    return w;
  endfunction

  // One clock: update the model for the edge just taken, then compare outputs.
  task automatic step();
    exp_t e;
    int   r, c;
    bit   v;
    @(negedge clk);
    cyc++;
    m_acc = 0;
    if (!rst) begin
      m_run = 0; m_done = 0; m_cnt = 0;
      q1.delete(); q2.delete(); qd.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (in_valid) begin
        r = m_cnt / W;
        c = m_cnt % W;
        img[r][c] = in_data;
        e.cyc = cyc + LAT - 1;
        e.dat = model_window(r, c);
        if (emits(r, c, 1)) q1.push_back(e);
        if (emits(r, c, 2)) q2.push_back(e);
        m_acc = 1;
        m_cnt++;
        if (m_cnt == W * H) begin
          m_run = 0; m_done = 1; m_cnt = 0;
          qd.push_back(cyc + LAT - 1);
        end
      end
    end else if (start) begin
      m_run = 1; m_cnt = 0;
    end

    chk("in_ready_s1", WD'(in_ready1), WD'(m_run));
    chk("in_ready_s2", WD'(in_ready2), WD'(m_run));

    v = (q1.size() > 0) && (q1[0].cyc == cyc);
    chk("win_valid_s1", WD'(win_valid1), WD'(v));
    if (v) begin
      chk("win_data_s1", win_data1, q1[0].dat);
      void'(q1.pop_front());
    end
    v = (q2.size() > 0) && (q2[0].cyc == cyc);
    chk("win_valid_s2", WD'(win_valid2), WD'(v));
    if (v) begin
      chk("win_data_s2", win_data2, q2[0].dat);
      void'(q2.pop_front());
    end
    v = (qd.size() > 0) && (qd[0] == cyc);
    chk("frame_done_s1", WD'(frame_done1), WD'(v));
    chk("frame_done_s2", WD'(frame_done2), WD'(v));
    if (v) void'(qd.pop_front());

    if (!rst) begin
      chk("rst_data_s1", win_data1, '0);
      chk("rst_data_s2", win_data2, '0);
    end

    if (win_valid1) begin
      n1++;
      if (n1 == 1) first1 = win_data1;
      last1 = win_data1;
    end
    if (win_valid2) begin
      n2++;
      if (n2 == 2) second2 = win_data2;
    end
  endtask

  task automatic do_reset();
    in_valid = 0;
    start    = 0;
    rst      = 0;
    step();
    step();
    rst = 1;
    step();
  endtask

  // mode 0: pixel = index+1 (= 5r+c+1); mode 1: random.
  // stall 0: none; 1: 3 idle cycles before every 4th pixel; 2: random gaps.
  task automatic run_frame(input int mode, input int stall, input int abort_at, input bit mid_start);
    int            pix, hold, budget;
    logic [DW-1:0] val;
    n1 = 0;
    n2 = 0;
    pix = 0;
    hold = 0;
    val = (mode == 0) ? DW'(1) : DW'($urandom);
    // in_valid held high while idle must not be accepted.
    in_data  = val;
    in_valid = 1;
    start    = 1;
    step();
    start  = 0;
    budget = 0;
    while (pix < W * H && budget < 2000) begin
      budget++;
      if (stall == 1) begin
        if (pix % 4 == 3 && hold < 3) begin
          in_valid = 0;
          hold++;
        end else begin
          in_valid = 1;
        end
      end else if (stall == 2) begin
        in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1;
      end
      in_data = val;
      start   = mid_start && (pix == 7);
      step();
      start = 0;
      if (m_acc) begin
        pix++;
        hold = 0;
        val = (mode == 0) ? DW'(pix + 1) : DW'($urandom);
        if (pix == abort_at) begin
          do_reset();
          return;
        end
      end
    end
    in_valid = 0;
    budget = 0;
    while ((m_run || m_done || q1.size() > 0 || q2.size() > 0 || qd.size() > 0) && budget < 50) begin
      budget++;
      step();
    end
    chk("frame_timeout", WD'(m_run || m_done || q1.size() > 0 || q2.size() > 0 || qd.size() > 0), '0);
  endtask

  initial begin
    rst      = 0;
    start    = 0;
    in_valid = 0;
    in_data  = '0;
    step();
    chk("reset_data_s1", win_data1, '0);
    chk("reset_valid_s1", WD'(win_valid1), '0);
    chk("reset_ready_s1", WD'(in_ready1), '0);
    step();
    rst = 1;
    step();

    // Directed frame, no stalls.
    run_frame(0, 0, -1, 0);
    chk("s1_count", WD'(n1), WD'(N1));
    chk("s1_first", first1, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
    chk("s1_last", last1, pack9(13, 14, 15, 18, 19, 20, 23, 24, 25));
    chk("s2_count", WD'(n2), WD'(N2));
    chk("s2_second", second2, pack9(3, 4, 5, 8, 9, 10, 13, 14, 15));

    // Same image with periodic stalls.
    run_frame(0, 1, -1, 0);
    chk("stall_s1_count", WD'(n1), WD'(N1));
    chk("stall_s1_first", first1, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
    chk("stall_s1_last", last1, pack9(13, 14, 15, 18, 19, 20, 23, 24, 25));
    chk("stall_s2_count", WD'(n2), WD'(N2));

    // Random data, random gaps, stray start mid-frame, then back-to-back frame.
    run_frame(1, 2, -1, 1);
    chk("midstart_s1_count", WD'(n1), WD'(N1));
    chk("midstart_s2_count", WD'(n2), WD'(N2));
    run_frame(1, 0, -1, 0);
    chk("b2b_s1_count", WD'(n1), WD'(N1));
    chk("b2b_s2_count", WD'(n2), WD'(N2));

    // Reset after 12 pixels, then a full frame.
    run_frame(1, 0, 12, 0);
    chk("abort_ready", WD'(in_ready1), '0);
    chk("abort_valid", WD'(win_valid1), '0);
    chk("abort_done", WD'(frame_done1), '0);
    chk("abort_data", win_data1, '0);
    run_frame(1, 2, -1, 0);
    chk("post_rst_s1_count", WD'(n1), WD'(N1));
    chk("post_rst_s2_count", WD'(n2), WD'(N2));

    for (int f = 0; f < 3; f++) begin
      run_frame(1, 2, -1, 1);
      chk("rand_s1_count", WD'(n1), WD'(N1));
      chk("rand_s2_count", WD'(n2), WD'(N2));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
